seq_gen_serial: RTL

- Serial bit-pattern generator. It is the transmit-side counterpart to the serial sequence detectors (e.g. the 101 detector).
- Accepts a parallel pattern word, a pattern length and a repeat count on a start strobe. Shifts the pattern out MSB-first on a single serial line, one bit per clock, with a qualifying valid signal.
- Its x output drives detector x inputs directly, for stimulus generation and self-checking loopback.

---
 rtl/seq_gen_serial.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/seq_gen_serial.sv
// ----------------------------------------------------------------------------
// seq_gen_serial
//   Serial bit-pattern generator. On an accepted start it latches a parallel
//   pattern, a length and a repeat count. It then shifts pattern[len-1]
//   down to pattern[0] out on x, one bit per clock, with valid qualifying
//   every bit. The pass is repeated rpt+1 times back to back with no gap,
//   and a single done cycle follows.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   start    in   request strobe, honoured only in IDLE
//   pattern  in   [WIDTH-1:0] bits to send, pattern[len-1] first
//   len      in   [LEN_W-1:0] bits per pass, legal 1..WIDTH
//   rpt      in   [RPT_W-1:0] extra passes (total passes = rpt+1)
//   x        out  serial data, 0 when valid=0
//   valid    out  x carries a pattern bit
//   busy     out  stream in progress, through the done cycle
//   done     out  one-cycle pulse after the final bit
//   err      out  one-cycle pulse for a start rejected for illegal len
// ----------------------------------------------------------------------------
module seq_gen_serial #(
    parameter  int WIDTH = 8,
    parameter  int RPT_W = 4,
    localparam int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [RPT_W-1:0] rpt,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;       // bits still to send this pass, next bit at MSB
    logic [LEN_W-1:0] cnt_q, cnt_d;     // bits left in this pass, including the one on x
    logic [RPT_W-1:0] pass_q, pass_d;   // passes left after the current one
    logic [WIDTH-1:0] pat_q, pat_d;     // latched copy for reloading between passes
    logic [LEN_W-1:0] len_q, len_d;
    logic             x_q, x_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] load_new;         // incoming pattern, first bit moved to the MSB
    logic [WIDTH-1:0] load_rep;         // latched pattern, first bit moved to the MSB
    logic             len_ok;

    // Left-justify the active bits so the first bit to send is at the MSB.
    function automatic logic [WIDTH-1:0] align_msb(input logic [WIDTH-1:0] p,
                                                   input logic [LEN_W-1:0] l);
        return p << (WIDTH - int'(l));
    endfunction

    assign load_new = align_msb(pattern, len);
    assign load_rep = align_msb(pat_q, len_q);
    assign len_ok   = (len != '0) && (len <= LEN_W'(WIDTH));

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        pat_d   = pat_q;
        len_d   = len_q;
        x_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && len_ok) begin
                    // The first bit goes straight onto x so it appears the
                    // cycle after acceptance; the shifter holds the rest.
                    pat_d   = pattern;
                    len_d   = len;
                    pass_d  = rpt;
                    x_d     = load_new[WIDTH-1];
                    sr_d    = load_new << 1;
                    cnt_d   = len;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end

            S_SHIFT: begin
                if (cnt_q != LEN_W'(1)) begin
                    x_d     = sr_q[WIDTH-1];
                    sr_d    = sr_q << 1;
                    cnt_d   = cnt_q - LEN_W'(1);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (pass_q != '0) begin
                    // Last bit of a non-final pass: reload so the next pass
                    // starts on the very next cycle.
                    pass_d  = pass_q - RPT_W'(1);
                    x_d     = load_rep[WIDTH-1];
                    sr_d    = load_rep << 1;
                    cnt_d   = len_q;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            pass_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign x     = x_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule
